// File: rtl/ternary_serial_alu_ctrl.sv
// Serial ternary ALU controller: one shared trit unit walks the operand
// words LSB trit first and returns the whole result word with a sticky error.
module ternary_serial_alu_ctrl #(
  parameter int TRITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [2*TRITS-1:0] a,
  input  logic [2*TRITS-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*TRITS-1:0] result,
  output logic               err,
  output logic               busy
);

  localparam int W  = 2 * TRITS;
  localparam int IW = $clog2(TRITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  result_q;
  logic          err_q;
  logic          out_valid_q;

  logic [1:0] ta;
  logic [1:0] tb;
  logic [1:0] rt;
  logic [2:0] sum;
  logic       bad;
  logic       last;

  always_comb begin
    ta = 2'b00;
    tb = 2'b00;
    for (int i = 0; i < TRITS; i++) begin
      if (idx == IW'(i)) begin
        ta = a_q[2*i +: 2];
        tb = b_q[2*i +: 2];
      end
    end
  end

  assign bad  = (ta == 2'b11) || (tb == 2'b11);
  assign sum  = {1'b0, ta} + {1'b0, tb};
  assign last = (idx == IW'(TRITS - 1));

  // Encodings equal trit values, so plain compares order trits.
  always_comb begin
    rt = 2'b00;
    unique case (1'b1)
      op_q == 2'b00: rt = (ta < tb) ? ta : tb;
      op_q == 2'b01: rt = (ta > tb) ? ta : tb;
      op_q == 2'b10: rt = (ta == tb) ? ta : 2'b01;
      op_q == 2'b11: begin
        if (sum == 3'd0)
          rt = 2'b00;
        else if (sum >= 3'd3)
          rt = 2'b10;
        else
          rt = 2'(sum - 3'd1);
      end
    endcase
    if (bad)
      rt = 2'b00;
  end

  // DONE spends one settle cycle before raising out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            idx      <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < TRITS; i++) begin
            if (idx == IW'(i))
              result_q[2*i +: 2] <= rt;
          end
          err_q <= err_q | bad;
          if (last)
            state <= S_DONE;
          else
            idx <= idx + IW'(1);
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ternary_serial_alu_ctrl.sv
// Directed bench for ternary_serial_alu_ctrl: vector table plus
// hand-written DONE-stall and mid-RUN reset sequences.
module tb_ternary_serial_alu_ctrl;

  localparam int TRITS = 6;
  localparam int W     = 2 * TRITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         err;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  vec_t vecs[11];

  ternary_serial_alu_ctrl #(.TRITS(TRITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " result"}, 32'(result), 32'd0);
    chk({nm, " err"}, 32'(err), 32'd0);
  endtask

  // Hold > 0 stalls DONE with in_valid high before the handshake.
  task automatic do_txn(input vec_t v, input string nm, input int hold);
    int cnt;
    @(negedge clk);
    chk({nm, " ready"}, 32'(in_ready), 32'd1);
    op       = v.op;
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = ~v.op;
    a        = '1;
    b        = '1;
    chk({nm, " busy"}, 32'(busy), 32'd1);
    chk({nm, " clr"}, 32'(result), 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({nm, " lat"}, 32'(cnt), 32'd7);
    chk({nm, " res"}, 32'(result), 32'(v.res));
    chk({nm, " err"}, 32'(err), 32'(v.err));
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        chk({nm, " hold v"}, 32'(out_valid), 32'd1);
        chk({nm, " hold r"}, 32'(result), 32'(v.res));
        chk({nm, " hold rdy"}, 32'(in_ready), 32'd0);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, " hs v"}, 32'(out_valid), 32'd0);
    chk({nm, " hs rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 12'hAAA, 12'h000, 12'h000, 1'b0};
    vecs[1]  = '{2'b01, 12'hAAA, 12'h000, 12'hAAA, 1'b0};
    vecs[2]  = '{2'b10, 12'hAAA, 12'h000, 12'h555, 1'b0};
    vecs[3]  = '{2'b11, 12'hAAA, 12'h000, 12'h555, 1'b0};
    vecs[4]  = '{2'b11, 12'h555, 12'h555, 12'h555, 1'b0};
    vecs[5]  = '{2'b11, 12'hAAA, 12'hAAA, 12'hAAA, 1'b0};
    vecs[6]  = '{2'b11, 12'h000, 12'h000, 12'h000, 1'b0};
    vecs[7]  = '{2'b01, 12'h003, 12'h000, 12'h000, 1'b1};
    vecs[8]  = '{2'b00, 12'hAAA, 12'h000, 12'h000, 1'b0};
    vecs[9]  = '{2'b10, 12'h006, 12'h006, 12'h006, 1'b0};
    vecs[10] = '{2'b01, 12'h000, 12'hC00, 12'h000, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    #1;
    chk_reset_vals("por");
    #22;
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      do_txn(vecs[i], $sformatf("vec%0d", i), 0);

    do_txn(vecs[1], "stall", 5);

    // Abort mid-RUN with an asynchronous reset.
    @(negedge clk);
    op       = 2'b01;
    a        = 12'hAAA;
    b        = 12'h000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("abandon v", 32'(out_valid), 32'd0);
    end
    do_txn(vecs[3], "post-rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
